soc_sysid_checker: RTL and testbench

//  Avalon-MM read master that interrogates the system-ID slave: reads word 0 (ID) and word 1 (timestamp).

---
 rtl/soc_sysid_pkg.sv | 31 +++
 rtl/soc_sysid_checker_if.sv | 28 ++
 rtl/soc_sysid_timeout_ctr.sv | 37 +++
 rtl/soc_sysid_checker.sv | 240 ++++++++++++++++++++++++
 tb/tb_soc_sysid_checker.sv | 342 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/soc_sysid_pkg.sv
// Shared types and constants for the system-ID checker and its helpers:
// FSM state encoding, word offsets inside the sysid slave and the width
// of the per-read timeout counter.
`timescale 1ns/1ps
package soc_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_FINISH  = 3'd5
    } sysid_chk_state_t;

    localparam int ID_OFS    = 0;   // word offset of the ID register
    localparam int TS_OFS    = 1;   // word offset of the timestamp register
    localparam int TMO_CNT_W = 16;  // timeout counter width

    // True in the states that drive avm_read.
    function automatic logic is_req_state(input sysid_chk_state_t s);
        return (s == ST_ID_REQ) || (s == ST_TS_REQ);
    endfunction

    // True in the states where a read is in flight (timeout counting).
    function automatic logic is_bus_state(input sysid_chk_state_t s);
        return (s == ST_ID_REQ) || (s == ST_ID_WAIT) ||
               (s == ST_TS_REQ) || (s == ST_TS_WAIT);
    endfunction

endpackage

// File: rtl/soc_sysid_checker_if.sv
// Avalon-MM read-only bus between the sysid checker (master) and the
// system-ID slave.
`timescale 1ns/1ps
interface soc_sysid_checker_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic              avm_readdatavalid;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata,
        input  avm_readdatavalid
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata,
        output avm_readdatavalid
    );
endinterface

// File: rtl/soc_sysid_timeout_ctr.sv
// Generic clear / enable / terminal-count counter used as a bus-read
// watchdog. tc is high in the cycle whose increment would make the count
// equal LIMIT, so LIMIT cycles of enable end with tc.
`timescale 1ns/1ps
module soc_sysid_timeout_ctr #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned LIMIT = 255
)(
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    localparam logic [CNT_W-1:0] TC_VAL   = CNT_W'(LIMIT - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] count_r;

    // Count register: clear wins over enable, saturates at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (en && (count_r != CNT_MAX)) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign tc = en && (count_r >= TC_VAL);

endmodule

// File: rtl/soc_sysid_checker.sv
// Avalon-MM read master that reads sysid word 0 (ID) and word 1
// (timestamp), compares them with build-time values and reports
// pass / fail with a per-read timeout.
// Optional feature: define SYSID_CHECK_RETRY_EN to retry a failed check
// up to MAX_RETRY times before reporting.
`timescale 1ns/1ps
module soc_sysid_checker
    import soc_sysid_pkg::*;
#(
    parameter int unsigned        ADDR_W         = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR      = '0,
    parameter logic [31:0]        EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0]        EXPECTED_TS    = 32'h6379_8FF1,
    parameter int unsigned        TIMEOUT_CYCLES = 255,
    parameter bit                 AUTO_START     = 1'b1,
    parameter int unsigned        MAX_RETRY      = 3
)(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    soc_sysid_checker_if.master  avm,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout_err,
    output logic [31:0]          id_value,
    output logic [31:0]          ts_value
);

    localparam logic [ADDR_W-1:0] ID_ADDR = BASE_ADDR + ADDR_W'(ID_OFS);
    localparam logic [ADDR_W-1:0] TS_ADDR = BASE_ADDR + ADDR_W'(TS_OFS);

    sysid_chk_state_t  state_r, state_nxt;

    logic              avm_read_r;
    logic [ADDR_W-1:0] avm_address_r, addr_nxt;
    logic              busy_r, done_r, pass_r, timeout_err_r;
    logic [31:0]       id_value_r, ts_value_r;
    logic              auto_pend_r, auto_nxt;

    logic [31:0]       id_nxt, ts_nxt;
    logic              tmo_nxt, pass_nxt, done_nxt;
    logic              pass_eval_s, last_attempt_s;
    logic              accept_s, tc_s, tmo_clr_s, tmo_en_s;

`ifdef SYSID_CHECK_RETRY_EN
    localparam int unsigned      RETRY_W     = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] RETRY_ONE   = RETRY_W'(1);
    logic [RETRY_W-1:0] retry_cnt_r, retry_nxt;
`else
    logic [31:0] unused_max_retry_s;
    assign unused_max_retry_s = 32'(MAX_RETRY);
`endif

    // A request is accepted in any cycle we drive read and the slave does not stall.
    assign accept_s  = avm_read_r && !avm.avm_waitrequest;
    assign tmo_en_s  = is_bus_state(state_r);
    assign tmo_clr_s = is_req_state(state_nxt) && (state_nxt != state_r);

    soc_sysid_timeout_ctr #(
        .CNT_W (TMO_CNT_W),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_tmo (
        .clock (clock),
        .reset (reset),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .tc    (tc_s)
    );

    // Next-state, data capture and result evaluation.
    always_comb begin
        state_nxt   = state_r;
        id_nxt      = id_value_r;
        ts_nxt      = ts_value_r;
        tmo_nxt     = timeout_err_r;
        pass_nxt    = pass_r;
        done_nxt    = 1'b0;
        auto_nxt    = auto_pend_r;
        addr_nxt    = avm_address_r;
        pass_eval_s = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
        retry_nxt      = retry_cnt_r;
        last_attempt_s = (retry_cnt_r >= RETRY_LIMIT);
`else
        last_attempt_s = 1'b1;
`endif

        case (state_r)
            ST_IDLE: begin
                if (start || auto_pend_r) begin
                    state_nxt = ST_ID_REQ;
                    pass_nxt  = 1'b0;
                    tmo_nxt   = 1'b0;
                    auto_nxt  = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
                    retry_nxt = {RETRY_W{1'b0}};
`endif
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_ID_REQ: begin
                if (accept_s && avm.avm_readdatavalid) begin
                    id_nxt    = avm.avm_readdata;
                    state_nxt = ST_TS_REQ;
                end else if (tc_s) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_FINISH;
                end else if (accept_s) begin
                    state_nxt = ST_ID_WAIT;
                end else begin
                    state_nxt = ST_ID_REQ;
                end
            end
            ST_ID_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    id_nxt    = avm.avm_readdata;
                    state_nxt = ST_TS_REQ;
                end else if (tc_s) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_ID_WAIT;
                end
            end
            ST_TS_REQ: begin
                if (accept_s && avm.avm_readdatavalid) begin
                    ts_nxt    = avm.avm_readdata;
                    state_nxt = ST_FINISH;
                end else if (tc_s) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_FINISH;
                end else if (accept_s) begin
                    state_nxt = ST_TS_WAIT;
                end else begin
                    state_nxt = ST_TS_REQ;
                end
            end
            ST_TS_WAIT: begin
                if (avm.avm_readdatavalid) begin
                    ts_nxt    = avm.avm_readdata;
                    state_nxt = ST_FINISH;
                end else if (tc_s) begin
                    tmo_nxt   = 1'b1;
                    state_nxt = ST_FINISH;
                end else begin
                    state_nxt = ST_TS_WAIT;
                end
            end
            ST_FINISH: begin
`ifdef SYSID_CHECK_RETRY_EN
                if (!pass_r && (retry_cnt_r < RETRY_LIMIT)) begin
                    state_nxt = ST_ID_REQ;
                    retry_nxt = retry_cnt_r + RETRY_ONE;
                    tmo_nxt   = 1'b0;
                end else begin
                    state_nxt = ST_IDLE;
                end
`else
                state_nxt = ST_IDLE;
`endif
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Result is judged on entry to FINISH so pass is valid with done.
        if ((state_nxt == ST_FINISH) && (state_r != ST_FINISH)) begin
            pass_eval_s = (id_nxt == EXPECTED_ID) && (ts_nxt == EXPECTED_TS) && !tmo_nxt;
            pass_nxt    = pass_eval_s;
            done_nxt    = pass_eval_s || last_attempt_s;
        end else begin
            done_nxt    = 1'b0;
        end

        case (state_nxt)
            ST_ID_REQ, ST_ID_WAIT: addr_nxt = ID_ADDR;
            ST_TS_REQ, ST_TS_WAIT: addr_nxt = TS_ADDR;
            default:               addr_nxt = avm_address_r;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Registered bus outputs, status flags and captured words.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            avm_read_r    <= 1'b0;
            avm_address_r <= BASE_ADDR;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            pass_r        <= 1'b0;
            timeout_err_r <= 1'b0;
            id_value_r    <= 32'h0000_0000;
            ts_value_r    <= 32'h0000_0000;
            auto_pend_r   <= AUTO_START;
        end else begin
            avm_read_r    <= is_req_state(state_nxt);
            avm_address_r <= addr_nxt;
            busy_r        <= (state_nxt != ST_IDLE);
            done_r        <= done_nxt;
            pass_r        <= pass_nxt;
            timeout_err_r <= tmo_nxt;
            id_value_r    <= id_nxt;
            ts_value_r    <= ts_nxt;
            auto_pend_r   <= auto_nxt;
        end
    end

`ifdef SYSID_CHECK_RETRY_EN
    // Attempt counter, cleared by each new start.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retry_cnt_r <= {RETRY_W{1'b0}};
        end else begin
            retry_cnt_r <= retry_nxt;
        end
    end
`endif

    assign avm.avm_read    = avm_read_r;
    assign avm.avm_address = avm_address_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign timeout_err     = timeout_err_r;
    assign id_value        = id_value_r;
    assign ts_value        = ts_value_r;

endmodule

// File: tb/tb_soc_sysid_checker.sv
// Directed testbench for soc_sysid_checker with a small reactive sysid
// slave (configurable stall, latency, muting and bad-data injection).
`timescale 1ns/1ps
module tb_soc_sysid_checker;

    localparam logic [31:0] EXP_ID = 32'h0000_0000;
    localparam logic [31:0] EXP_TS = 32'h6379_8FF1;

`ifdef SYSID_CHECK_RETRY_EN
    localparam int T3_TS_READS = 3;
    localparam int T4_DONE_CYC = 26;
`else
    localparam int T3_TS_READS = 1;
    localparam int T4_DONE_CYC = 8;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, pass, timeout_err;
    logic [31:0] id_value, ts_value;

    soc_sysid_checker_if #(.ADDR_W(32)) bus ();

    soc_sysid_checker #(
        .ADDR_W         (32),
        .BASE_ADDR      (32'h0000_0000),
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (8),
        .AUTO_START     (1'b1),
        .MAX_RETRY      (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .avm         (bus.master),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout_err (timeout_err),
        .id_value    (id_value),
        .ts_value    (ts_value)
    );

    always #5 clock = ~clock;

    // slave configuration and statistics
    int          stall_cfg = 0;
    int          lat_cfg = 1;
    bit          mute_id = 1'b0;
    bit          mute_ts = 1'b0;
    int          ts_bad_left = 0;
    logic [31:0] id_data = 32'h0000_0000;
    logic [31:0] ts_data = 32'h6379_8FF1;
    logic [31:0] ts_bad_data = 32'hFFFF_0000;
    bit          inj_rdv = 1'b0;
    logic [31:0] inj_data = 32'h0000_0000;
    int          id_acc = 0;
    int          ts_acc = 0;
    int          stall_cnt = 0;
    int          stall_viol = 0;
    logic [31:0] acc_addr_q[$];

    int          sl_stall_left = 0;
    int          sl_pend_cnt = -1;
    logic [31:0] sl_pend_data = 32'h0;
    bit          sl_prev_stall = 1'b0;
    logic [31:0] sl_prev_addr = 32'h0;
    logic [31:0] sl_data;
    bit          sl_mute;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reactive slave: drives the bus at each falling edge for the coming cycle.
    initial begin
        bus.avm_waitrequest   = 1'b0;
        bus.avm_readdatavalid = 1'b0;
        bus.avm_readdata      = 32'h0;
        forever begin
            @(negedge clock);
            if (sl_prev_stall && !reset && (!bus.avm_read || bus.avm_address != sl_prev_addr))
                stall_viol++;
            sl_prev_stall         = 1'b0;
            bus.avm_waitrequest   = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = 32'h0;
            if (reset) begin
                sl_stall_left = stall_cfg;
                sl_pend_cnt   = -1;
            end else begin
                if (sl_pend_cnt == 0) begin
                    bus.avm_readdatavalid = 1'b1;
                    bus.avm_readdata      = sl_pend_data;
                    sl_pend_cnt           = -1;
                end else if (sl_pend_cnt > 0) begin
                    sl_pend_cnt--;
                end
                if (bus.avm_read) begin
                    if (sl_stall_left > 0) begin
                        bus.avm_waitrequest = 1'b1;
                        sl_stall_left--;
                        stall_cnt++;
                        sl_prev_stall = 1'b1;
                        sl_prev_addr  = bus.avm_address;
                    end else begin
                        acc_addr_q.push_back(bus.avm_address);
                        sl_stall_left = stall_cfg;
                        if (bus.avm_address == 32'd1) begin
                            ts_acc++;
                            sl_mute = mute_ts;
                            if (ts_bad_left > 0) begin
                                sl_data = ts_bad_data;
                                ts_bad_left--;
                            end else begin
                                sl_data = ts_data;
                            end
                        end else begin
                            id_acc++;
                            sl_mute = mute_id;
                            sl_data = id_data;
                        end
                        if (!sl_mute) begin
                            if (lat_cfg == 0) begin
                                bus.avm_readdatavalid = 1'b1;
                                bus.avm_readdata      = sl_data;
                            end else begin
                                sl_pend_cnt  = lat_cfg - 1;
                                sl_pend_data = sl_data;
                            end
                        end
                    end
                end else begin
                    sl_stall_left = stall_cfg;
                end
            end
            if (inj_rdv) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = inj_data;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int limit, output int busy_cyc, output int done_cnt, output bit finished);
        bit seen;
        seen = 1'b0;
        busy_cyc = 0;
        done_cnt = 0;
        finished = 1'b0;
        for (int i = 0; i < limit && !finished; i++) begin
            @(negedge clock);
            if (done) done_cnt++;
            if (busy) begin
                busy_cyc++;
                seen = 1'b1;
            end else if (seen) begin
                finished = 1'b1;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_read"},  {31'd0, bus.avm_read}, 32'd0);
        check_value({tag, "_addr"},  bus.avm_address, 32'h0000_0000);
        check_value({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check_value({tag, "_done"},  {31'd0, done}, 32'd0);
        check_value({tag, "_pass"},  {31'd0, pass}, 32'd0);
        check_value({tag, "_tmo"},   {31'd0, timeout_err}, 32'd0);
        check_value({tag, "_id"},    id_value, 32'h0000_0000);
        check_value({tag, "_ts"},    ts_value, 32'h0000_0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  bc, dc, cyc, base_id, base_ts;
        bit  fin, found;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("rst");

        // Test 1: auto-start after reset, latency-1 slave
        acc_addr_q.delete();
        reset = 1'b0;
        run_to_idle(50, bc, dc, fin);
        check_value("t1_finished", {31'd0, fin}, 32'd1);
        check_value("t1_busy_le6", {31'd0, (bc <= 6)}, 32'd1);
        check_value("t1_done_cnt", dc, 32'd1);
        check_value("t1_pass", {31'd0, pass}, 32'd1);
        check_value("t1_tmo", {31'd0, timeout_err}, 32'd0);
        check_value("t1_id", id_value, 32'h0000_0000);
        check_value("t1_ts", ts_value, 32'h6379_8FF1);
        check_value("t1_nreads", acc_addr_q.size(), 32'd2);
        if (acc_addr_q.size() == 2) begin
            check_value("t1_addr0", acc_addr_q[0], 32'h0000_0000);
            check_value("t1_addr1", acc_addr_q[1], 32'h0000_0001);
        end

        // Stray readdatavalid while idle is ignored
        inj_data = 32'hDEAD_BEEF;
        inj_rdv  = 1'b1;
        repeat (2) @(negedge clock);
        inj_rdv  = 1'b0;
        repeat (2) @(negedge clock);
        check_value("idle_rdv_id", id_value, 32'h0000_0000);
        check_value("idle_rdv_ts", ts_value, 32'h6379_8FF1);
        check_value("idle_rdv_busy", {31'd0, busy}, 32'd0);

        // Zero-latency slave: data in the acceptance cycle
        lat_cfg = 0;
        acc_addr_q.delete();
        pulse_start();
        run_to_idle(50, bc, dc, fin);
        check_value("lat0_finished", {31'd0, fin}, 32'd1);
        check_value("lat0_done_cnt", dc, 32'd1);
        check_value("lat0_pass", {31'd0, pass}, 32'd1);
        check_value("lat0_ts", ts_value, 32'h6379_8FF1);
        check_value("lat0_nreads", acc_addr_q.size(), 32'd2);
        lat_cfg = 1;

        // Test 2: 3-cycle stall on each read
        stall_cfg  = 3;
        stall_cnt  = 0;
        stall_viol = 0;
        @(negedge clock);
        pulse_start();
        run_to_idle(60, bc, dc, fin);
        check_value("t2_finished", {31'd0, fin}, 32'd1);
        check_value("t2_stall_cnt", stall_cnt, 32'd6);
        check_value("t2_stable", stall_viol, 32'd0);
        check_value("t2_pass", {31'd0, pass}, 32'd1);
        check_value("t2_id", id_value, 32'h0000_0000);
        check_value("t2_ts", ts_value, 32'h6379_8FF1);
        stall_cfg = 0;
        @(negedge clock);

        // Test 3: wrong timestamp
        ts_data = 32'h6379_8FF0;
        base_ts = ts_acc;
        pulse_start();
        run_to_idle(200, bc, dc, fin);
        check_value("t3_finished", {31'd0, fin}, 32'd1);
        check_value("t3_done_cnt", dc, 32'd1);
        check_value("t3_pass", {31'd0, pass}, 32'd0);
        check_value("t3_tmo", {31'd0, timeout_err}, 32'd0);
        check_value("t3_ts", ts_value, 32'h6379_8FF0);
        check_value("t3_ts_reads", ts_acc - base_ts, T3_TS_READS);
        ts_data = EXP_TS;

        // Test 4: slave stalls forever, never returns data
        stall_cfg = 1000;
        mute_id   = 1'b1;
        @(negedge clock);
        pulse_start();
        check_value("t4_read_asserted", {31'd0, bus.avm_read}, 32'd1);
        cyc = 0;
        while (!done && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        check_value("t4_done_cycle", cyc, T4_DONE_CYC);
        check_value("t4_read_dropped", {31'd0, bus.avm_read}, 32'd0);
        check_value("t4_tmo", {31'd0, timeout_err}, 32'd1);
        check_value("t4_pass", {31'd0, pass}, 32'd0);
        @(negedge clock);
        check_value("t4_idle", {31'd0, busy}, 32'd0);
        stall_cfg = 0;
        mute_id   = 1'b0;
        @(negedge clock);

        // Test 5: start while busy, then reset during TS_WAIT
        mute_ts = 1'b1;
        base_id = id_acc;
        pulse_start();
        @(negedge clock);
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clock);
            if (bus.avm_address == 32'd1 && !bus.avm_read && busy) found = 1'b1;
        end
        check_value("t5_in_ts_wait", {31'd0, found}, 32'd1);
        #1 reset = 1'b1;
        #1 check_reset_outputs("t5_async");
        check_value("t5_single_check", id_acc - base_id, 32'd1);
        mute_ts  = 1'b0;
        @(negedge clock);
        inj_data = 32'h1234_5678;
        inj_rdv  = 1'b1;
        repeat (2) @(negedge clock);
        inj_rdv  = 1'b0;
        @(negedge clock);
        check_value("t5_late_rdv_id", id_value, 32'h0000_0000);
        check_value("t5_late_rdv_ts", ts_value, 32'h0000_0000);
        reset = 1'b0;
        run_to_idle(50, bc, dc, fin);
        check_value("t5_autostart_fin", {31'd0, fin}, 32'd1);
        check_value("t5_autostart_pass", {31'd0, pass}, 32'd1);
        check_value("t5_autostart_tmo", {31'd0, timeout_err}, 32'd0);

`ifdef SYSID_CHECK_RETRY_EN
        // Test 6: two bad attempts, third good
        ts_bad_left = 2;
        base_id     = id_acc;
        base_ts     = ts_acc;
        @(negedge clock);
        pulse_start();
        run_to_idle(200, bc, dc, fin);
        check_value("t6_finished", {31'd0, fin}, 32'd1);
        check_value("t6_id_reads", id_acc - base_id, 32'd3);
        check_value("t6_ts_reads", ts_acc - base_ts, 32'd3);
        check_value("t6_done_cnt", dc, 32'd1);
        check_value("t6_pass", {31'd0, pass}, 32'd1);
        check_value("t6_ts", ts_value, 32'h6379_8FF1);
`endif

        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
